// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Optional illegal-opcode trap is enabled by MULTICYCLE_ILLEGAL_TRAP_EN.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC_R   = 4'd6,
    ALUWB    = 4'd7,
    EXEC_I   = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    HALT     = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode only, independent of state.
  function automatic logic [1:0] imm_dec(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
// illegal_op exists only when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
interface multicycle_if #(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned ALUC_W  = 3
);
  logic [6:0]         op;
  logic [2:0]         funct3;
  logic               funct7b5;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               adr_src;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         imm_src;
  logic [ALUC_W-1:0]  alucontrol;
  logic [STATE_W-1:0] dbg_state;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic               illegal_op;
`endif

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alucontrol, dbg_state
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alucontrol, dbg_state
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );
endinterface

// File: rtl/multicycle_alu_dec.sv
// ALU function decoder: maps aluop and instruction fields to alucontrol.
module multicycle_alu_dec
  import multicycle_pkg::*;
#(
  parameter int unsigned ALUC_W = 3
) (
  input  aluop_t            aluop,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              op5,
  output logic [ALUC_W-1:0] alucontrol
);
  logic [2:0] alu;

  // Only R-type (op[5]=1) may select sub through funct7b5; addi never does.
  always_comb begin
    alu = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alu = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu = ALU_SLT;
          3'b110:  alu = ALU_OR;
          3'b111:  alu = ALU_AND;
          default: alu = ALU_ADD;
        endcase
      end
      default:     alu = ALU_ADD;
    endcase
  end

  assign alucontrol = ALUC_W'(alu);
endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle RV32I datapath with wait-state memory.
// MULTICYCLE_ILLEGAL_TRAP_EN: unknown opcodes trap into HALT and raise illegal_op.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned STATE_W = 4,
  parameter int unsigned ALUC_W  = 3
) (
  input  logic        clk,
  input  logic        rst,
  multicycle_if.master bus
);
  state_t state_q, state_d;
  logic   pc_update, branch;
  aluop_t aluop;

  // State register, asynchronously forced to FETCH while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // Next-state: memory states hold until mem_ready, others step unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC_R;
          OP_I:         state_d = EXEC_I;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      state_d = HALT;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      EXEC_R:   state_d = ALUWB;
      EXEC_I:   state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      HALT:     state_d = HALT;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Outputs from the current state; everything stays 0 while rst is low.
  always_comb begin
    pc_update      = 1'b0;
    branch         = 1'b0;
    aluop          = ALUOP_ADD;
    bus.adr_src    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    if (rst) begin
      case (state_q)
        FETCH: begin
          bus.mem_read   = 1'b1;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALU;
          bus.ir_write   = bus.mem_ready;
          pc_update      = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_IMM;
        end
        MEMADR: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_IMM;
        end
        MEMREAD: begin
          bus.mem_read = 1'b1;
          bus.adr_src  = 1'b1;
        end
        MEMWB: begin
          bus.result_src = RES_RDATA;
          bus.reg_write  = 1'b1;
        end
        MEMWRITE: begin
          bus.mem_write = 1'b1;
          bus.adr_src   = 1'b1;
        end
        EXEC_R: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_RS2;
          aluop         = ALUOP_FUNCT;
        end
        EXEC_I: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_IMM;
          aluop         = ALUOP_FUNCT;
        end
        JAL: begin
          bus.alu_src_a  = SRCA_OLDPC;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALUOUT;
          pc_update      = 1'b1;
        end
        ALUWB: begin
          bus.result_src = RES_ALUOUT;
          bus.reg_write  = 1'b1;
        end
        BEQ: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_RS2;
          aluop         = ALUOP_SUB;
          branch        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  multicycle_alu_dec #(.ALUC_W(ALUC_W)) u_alu_dec (
    .aluop      (aluop),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .op5        (bus.op[5]),
    .alucontrol (bus.alucontrol)
  );

  assign bus.pc_write  = pc_update | (branch & bus.zero);
  assign bus.imm_src   = rst ? imm_dec(bus.op) : IMM_I;
  assign bus.dbg_state = STATE_W'(state_q);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign bus.illegal_op = rst && (state_q == HALT);
`endif
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM that sequences a multi-cycle variant of the RV32I datapath: one shared instruction/data memory, a single ALU, and registered instruction/data/ALU-out stages.
- Each cycle it drives every mux select, write enable and the ALU function from the current state and the decoded instruction fields.
- It replaces the purely combinational control unit when the core runs multi-cycle against a memory that may insert wait states.

Parameters:
- STATE_W, 4, width of the state register (exposed on dbg_state).
- ALUC_W, 3, width of alucontrol.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0=PC, 1=ALU-out register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction/old-PC register enable
- reg_write  out  1  register file write enable
- result_src  out  2  00=ALU-out reg, 01=read-data reg, 10=ALU result
- alu_src_a  out  2  00=PC, 01=old PC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm_ext, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alucontrol  out  ALUC_W  000 add, 001 sub, 010 and, 011 or, 101 slt
- dbg_state  out  STATE_W  current state

Behaviour:
- Reset
  - rst=0 forces state to FETCH asynchronously.
  - While rst=0, all enables (pc_write, ir_write, reg_write, mem_read, mem_write) are 0 and all selects are 0.
  - After rst rises, the first clock edge is evaluated in FETCH.
  - Reset mid-access abandons the access; nothing is written.
- Outputs are Moore, except:
  - pc_write = pc_update | (branch & zero).
  - ir_write and pc_update in FETCH are gated by mem_ready.
- imm_src is decoded combinationally from op: lw/I-ALU→00, sw→01, beq→10, jal→11, other→00.
- States and transitions (unlisted outputs are 0):
  - FETCH: mem_read=1, adr_src=0, a=00, b=10, add, result_src=10, ir_write=pc_update=mem_ready. If mem_ready→DECODE, else hold.
  - DECODE: a=01, b=01, add (precomputes the branch target). op lw/sw→MEMADR; R(0110011)→EXEC_R; I(0010011)→EXEC_I; jal→JAL; beq→BEQ; other→FETCH.
  - MEMADR: a=10, b=01, add. lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD: mem_read=1, adr_src=1. mem_ready→MEMWB, else hold.
  - MEMWB: result_src=01, reg_write=1 →FETCH.
  - MEMWRITE: mem_write=1, adr_src=1, held until mem_ready. The memory commits on the edge where mem_write & mem_ready; then →FETCH.
  - EXEC_R: a=10, b=00, function decode →ALUWB.
  - EXEC_I: a=10, b=01, function decode →ALUWB.
  - JAL: a=01, b=10, add, result_src=00, pc_update=1 →ALUWB (writes the link address).
  - ALUWB: result_src=00, reg_write=1 →FETCH.
  - BEQ: a=10, b=00, sub, result_src=00, branch=1 →FETCH.
- ALU function decode (EXEC_R/EXEC_I):
  - funct3 000: sub if (R-type & funct7b5), else add.
  - 010: slt. 110: or. 111: and. Other: add.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Each wait cycle on mem_ready adds exactly one cycle in FETCH/MEMREAD/MEMWRITE, with outputs held stable.

Optional Feature:
- Macro MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown op in DECODE goes to HALT (dbg_state=4'hF), with all enables 0 and illegal_op output =1.
  - HALT is left only by reset.
- Undefined: unknown op returns to FETCH as a NOP; port illegal_op is absent.

Decomposition:
- Package multicycle_pkg holds:
  - state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, ALUWB=7, EXEC_I=8, JAL=9, BEQ=10, HALT=15
  - opcode constants
  - alucontrol and select encodings
- One sub-module, multicycle_alu_dec: pure combinational; aluop (00 add, 01 sub, 10 funct), funct3, funct7b5, op[5] → alucontrol.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-MEMWRITE → mem_write=0 immediately, dbg_state=0; after release, FETCH with mem_read=1.
- lw x5,4(x1), mem_ready=1 → states 0,1,2,3,4; reg_write=1 only in cycle 5 with result_src=01.
- sw with mem_ready low for 2 cycles in MEMWRITE → mem_write held 3 cycles, adr_src=1; then FETCH.
- add/sub/slt/or/and R-type → alucontrol 000/001/101/011/010 in EXEC_R; addi with funct7b5=1 gives 000, not sub.
- beq with zero=1 then zero=0 → pc_write=1 in BEQ only when zero=1; alucontrol=001; 3 cycles each.
- jal → pc_write=1 in JAL, reg_write in ALUWB with result_src=00; op=7'h7F → FETCH (macro off) or HALT with illegal_op=1 (macro on).
